// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle core sequencer: state codes,
// reset PC and the retire-time PC update.
package mc_pkg;

  typedef enum logic [2:0] {
    MC_FETCH  = 3'd0,
    MC_DECODE = 3'd1,
    MC_EXE    = 3'd2,
    MC_MEM    = 3'd3,
    MC_WB     = 3'd4
  } mc_state_t;

  localparam logic [31:0] MC_RESET_PC = 32'h1c00_0000;
  localparam logic [31:0] MC_PC_STEP  = 32'd4;

  // Sequential PC wraps naturally at 2^32 through the 32-bit add.
  function automatic logic [31:0] mc_pc_next(input logic [31:0] cur_pc,
                                             input logic        taken,
                                             input logic [31:0] target);
    return taken ? target : (cur_pc + MC_PC_STEP);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer: owns PC and IR, steps each instruction through
// FETCH/DECODE/EXE/MEM/WB and gates SRAM requests and regfile writes.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = MC_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_rdy,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] ir,
  input  logic        cls_br_nolink,
  input  logic        cls_load,
  input  logic        cls_store,
  input  logic        gr_we,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        data_sram_req,
  output logic        data_sram_we,
  input  logic        data_sram_rdy,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic [31:0] pc,
  output logic        retire
);

  localparam logic [2:0] S_FETCH  = 3'(MC_FETCH);
  localparam logic [2:0] S_DECODE = 3'(MC_DECODE);
  localparam logic [2:0] S_EXE    = 3'(MC_EXE);
  localparam logic [2:0] S_MEM    = 3'(MC_MEM);
  localparam logic [2:0] S_WB     = 3'(MC_WB);

  logic [2:0] next_state;
  logic       ir_load;

  assign inst_sram_addr = pc;

  // Next-state and per-state strobes; outputs fall to idle as soon as reset forces FETCH.
  always_comb begin
    next_state    = state;
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    data_sram_we  = 1'b0;
    rf_we         = 1'b0;
    retire        = 1'b0;
    ir_load       = 1'b0;
    case (state)
      S_FETCH: begin
        inst_sram_req = 1'b1;
        if (inst_sram_rdy) begin
          ir_load    = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cls_br_nolink) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (cls_load || cls_store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        data_sram_req = 1'b1;
        data_sram_we  = cls_store;
        if (data_sram_rdy) begin
          if (cls_store) begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else begin
          next_state = S_MEM;
        end
      end
      S_WB: begin
        rf_we      = gr_we;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // State, PC and IR registers; PC moves only on retire, IR only on a completed fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= 32'h0000_0000;
    end else begin
      state <= next_state;
      if (retire) begin
        pc <= mc_pc_next(pc, br_taken, br_target);
      end
      if (ir_load) begin
        ir <= inst_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: the bench plays decoder and SRAMs and
// checks each cycle against hand-computed values.
module tb_mc_ctrl_fsm;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_rdy;
  logic [31:0] inst_sram_rdata;
  logic [31:0] ir;
  logic        cls_br_nolink;
  logic        cls_load;
  logic        cls_store;
  logic        gr_we;
  logic        br_taken;
  logic [31:0] br_target;
  logic        data_sram_req;
  logic        data_sram_we;
  logic        data_sram_rdy;
  logic        rf_we;
  logic [2:0]  state;
  logic [31:0] pc;
  logic        retire;

  int checks;
  int failures;

  localparam logic [31:0] W_ADD = 32'h0010_1c85;
  localparam logic [31:0] W_LD  = 32'h2880_0085;
  localparam logic [31:0] W_BEQ = 32'h5800_0485;
  localparam logic [31:0] W_ST  = 32'h2980_0085;
  localparam logic [31:0] W_B   = 32'h5000_0400;

  mc_ctrl_fsm dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_req   (inst_sram_req),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdy   (inst_sram_rdy),
    .inst_sram_rdata (inst_sram_rdata),
    .ir              (ir),
    .cls_br_nolink   (cls_br_nolink),
    .cls_load        (cls_load),
    .cls_store       (cls_store),
    .gr_we           (gr_we),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .data_sram_req   (data_sram_req),
    .data_sram_we    (data_sram_we),
    .data_sram_rdy   (data_sram_rdy),
    .rf_we           (rf_we),
    .state           (state),
    .pc              (pc),
    .retire          (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cls(input logic br, input logic ld, input logic st, input logic we);
    cls_br_nolink = br;
    cls_load      = ld;
    cls_store     = st;
    gr_we         = we;
  endtask

  // Strobe snapshot: {inst_req, data_req, data_we, rf_we, retire}
  function automatic logic [31:0] strobes();
    return {27'd0, inst_sram_req, data_sram_req, data_sram_we, rf_we, retire};
  endfunction

  initial begin
    checks          = 0;
    failures        = 0;
    resetn          = 1'b0;
    inst_sram_rdy   = 1'b0;
    inst_sram_rdata = 32'h0000_0000;
    data_sram_rdy   = 1'b0;
    br_taken        = 1'b0;
    br_target       = 32'h0000_0000;
    set_cls(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_pc", pc, 32'h1c00_0000);
    check_val("rst_ir", ir, 32'h0000_0000);
    check_val("rst_strobes", strobes(), 32'b10000);
    resetn = 1'b1;

    // add.w, zero-wait fetch
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_ADD; #1;
    check_val("add_c1_addr", inst_sram_addr, 32'h1c00_0000);
    check_val("add_c1_state", 32'(state), 32'd0);
    check_val("add_c1_strobes", strobes(), 32'b10000);
    tick();
    inst_sram_rdy = 1'b1; inst_sram_rdata = 32'hdead_beef;
    set_cls(1'b0, 1'b0, 1'b0, 1'b1); #1;
    check_val("add_c2_state", 32'(state), 32'd1);
    check_val("add_c2_ir", ir, W_ADD);
    check_val("add_c2_strobes", strobes(), 32'b00000);
    tick();
    inst_sram_rdy = 1'b0; #1;
    check_val("add_c3_state", 32'(state), 32'd2);
    check_val("add_c3_ir_hold", ir, W_ADD);
    check_val("add_c3_strobes", strobes(), 32'b00000);
    tick();
    #1;
    check_val("add_c4_state", 32'(state), 32'd4);
    check_val("add_c4_strobes", strobes(), 32'b00011);
    check_val("add_c4_pc", pc, 32'h1c00_0000);
    tick();

    // ld.w with two MEM wait cycles
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_LD; set_cls(1'b0, 1'b0, 1'b0, 1'b0); #1;
    check_val("ld_c1_addr", inst_sram_addr, 32'h1c00_0004);
    check_val("ld_c1_strobes", strobes(), 32'b10000);
    tick();
    inst_sram_rdy = 1'b0; set_cls(1'b0, 1'b1, 1'b0, 1'b1); #1;
    check_val("ld_c2_state", 32'(state), 32'd1);
    tick();
    check_val("ld_c3_state", 32'(state), 32'd2);
    tick();
    for (int i = 0; i < 2; i++) begin
      data_sram_rdy = 1'b0; #1;
      check_val($sformatf("ld_wait%0d_state", i), 32'(state), 32'd3);
      check_val($sformatf("ld_wait%0d_strobes", i), strobes(), 32'b01000);
      tick();
    end
    data_sram_rdy = 1'b1; #1;
    check_val("ld_c6_strobes", strobes(), 32'b01000);
    tick();
    data_sram_rdy = 1'b0; #1;
    check_val("ld_c7_state", 32'(state), 32'd4);
    check_val("ld_c7_strobes", strobes(), 32'b00011);
    tick();

    // beq taken to 1c00_0100
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_BEQ; set_cls(1'b0, 1'b0, 1'b0, 1'b0); #1;
    check_val("beq_c1_addr", inst_sram_addr, 32'h1c00_0008);
    tick();
    inst_sram_rdy = 1'b0; set_cls(1'b1, 1'b0, 1'b0, 1'b0);
    br_taken = 1'b1; br_target = 32'h1c00_0100; #1;
    check_val("beq_c2_state", 32'(state), 32'd1);
    check_val("beq_c2_strobes", strobes(), 32'b00001);
    tick();
    br_taken = 1'b0; set_cls(1'b0, 1'b0, 1'b0, 1'b0); #1;
    check_val("beq_next_addr", inst_sram_addr, 32'h1c00_0100);
    check_val("beq_next_state", 32'(state), 32'd0);

    // st.w with one MEM wait cycle
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_ST; #1;
    tick();
    inst_sram_rdy = 1'b0; set_cls(1'b0, 1'b0, 1'b1, 1'b0); #1;
    check_val("st_c2_ir", ir, W_ST);
    tick();
    tick();
    data_sram_rdy = 1'b0; #1;
    check_val("st_wait_strobes", strobes(), 32'b01100);
    tick();
    data_sram_rdy = 1'b1; #1;
    check_val("st_done_state", 32'(state), 32'd3);
    check_val("st_done_strobes", strobes(), 32'b01101);
    tick();
    data_sram_rdy = 1'b0; set_cls(1'b0, 1'b0, 1'b0, 1'b0); #1;
    check_val("st_next_addr", inst_sram_addr, 32'h1c00_0104);

    // b to FFFF_FFFC, then ALU op there wraps PC to 0
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_B; #1;
    tick();
    inst_sram_rdy = 1'b0; set_cls(1'b1, 1'b0, 1'b0, 1'b0);
    br_taken = 1'b1; br_target = 32'hffff_fffc; #1;
    tick();
    br_taken = 1'b0; set_cls(1'b0, 1'b0, 1'b0, 1'b0);
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_ADD; #1;
    check_val("wrap_fetch_addr", inst_sram_addr, 32'hffff_fffc);
    tick();
    inst_sram_rdy = 1'b0; set_cls(1'b0, 1'b0, 1'b0, 1'b1); #1;
    tick();
    tick();
    check_val("wrap_wb_strobes", strobes(), 32'b00011);
    tick();
    set_cls(1'b0, 1'b0, 1'b0, 1'b0); #1;
    check_val("wrap_next_addr", inst_sram_addr, 32'h0000_0000);

    // load interrupted by reset during MEM wait
    inst_sram_rdy = 1'b1; inst_sram_rdata = W_LD; #1;
    tick();
    inst_sram_rdy = 1'b0; set_cls(1'b0, 1'b1, 1'b0, 1'b1); #1;
    tick();
    tick();
    data_sram_rdy = 1'b0; #1;
    check_val("rstmid_pre_strobes", strobes(), 32'b01000);
    resetn = 1'b0; #1;
    check_val("rstmid_strobes", strobes(), 32'b10000);
    check_val("rstmid_pc", pc, 32'h1c00_0000);
    tick();
    check_val("rstmid_hold_rf_we", 32'(rf_we), 32'd0);
    resetn = 1'b1; set_cls(1'b0, 1'b0, 1'b0, 1'b0); #1;
    tick();
    check_val("rstrel_state", 32'(state), 32'd0);
    check_val("rstrel_pc", pc, 32'h1c00_0000);
    check_val("rstrel_ir", ir, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Sequencing controller for the multi-cycle LoongArch core: owns the PC and instruction register, and steps each instruction through FETCH, DECODE, EXE, MEM and WB. It drives the instruction and data SRAM request handshakes, and gates register-file and memory writes to the correct cycle. It sits between the SRAM ports and the existing decoder, regfile, ALU and branch datapath, and replaces ad-hoc per-state enables in the top level.

## Interface
- `RESET_PC`, default 32'h1c00_0000, PC value loaded on reset.

- `clk`  in  1  core clock
- `resetn`  in  1  asynchronous, active-low reset
- `inst_sram_req`  out  1  instruction fetch request
- `inst_sram_addr`  out  32  fetch address, equals `pc`
- `inst_sram_rdy`  in  1  fetch data valid this cycle
- `inst_sram_rdata`  in  32  fetched instruction
- `ir`  out  32  instruction register, feeds the decoder
- `cls_br_nolink`  in  1  decoded b/beq/bne
- `cls_load`  in  1  decoded ld.w
- `cls_store`  in  1  decoded st.w
- `gr_we`  in  1  decoded destination write enable
- `br_taken`  in  1  branch/jump resolved taken
- `br_target`  in  32  branch/jump target
- `data_sram_req`  out  1  data access request
- `data_sram_we`  out  1  data write, valid with req
- `data_sram_rdy`  in  1  data access complete this cycle
- `rf_we`  out  1  regfile write strobe
- `state`  out  3  current state, for datapath muxing
- `pc`  out  32  current instruction PC, also `debug_wb_pc`
- `retire`  out  1  one-cycle pulse when an instruction completes

## Operation
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Codes 5–7 are illegal and go to FETCH next cycle.
- FETCH
  - `inst_sram_req`=1.
  - On `inst_sram_rdy`: `ir`<=`inst_sram_rdata`, go to DECODE.
  - Otherwise hold FETCH.
- DECODE
  - If `cls_br_nolink`: retire, go to FETCH.
  - Otherwise go to EXE.
- EXE
  - If `cls_load` or `cls_store`: go to MEM.
  - Otherwise go to WB.
- MEM
  - `data_sram_req`=1; `data_sram_we`=`cls_store`.
  - On `data_sram_rdy`:
    - load: go to WB.
    - store: retire, go to FETCH.
  - Otherwise hold MEM.
- WB
  - `rf_we`=`gr_we`.
  - Retire, go to FETCH.
- Retire cycle:
  - `retire`=1.
  - `pc` <= `br_taken` ? `br_target` : `pc`+4.
  - `pc` wraps modulo 2^32.
- `pc` and `ir` change only at retire and at FETCH-with-rdy respectively. Both are stable from DECODE through retire.
- Requests are held high until the matching rdy is sampled high. A rdy arriving while its req is low is ignored.
- Decoder class inputs are sampled only in DECODE, EXE and MEM. They are derived from `ir`, so they are stable there.
- Any encoding with none of `cls_br_nolink`, `cls_load`, `cls_store` set follows the ALU path. This includes jirl, bl and undefined encodings.

## Timing
- Reset (async assert, sync deassert handled by the integrator), all outputs:
  - `state`=FETCH, `pc`=`RESET_PC`, `ir`=0.
  - `rf_we`=0, `data_sram_req`=0, `data_sram_we`=0, `retire`=0.
  - `inst_sram_req`=1 (combinational from state).
- Reset asserted mid-access:
  - `data_sram_req` and `rf_we` drop immediately.
  - No write is committed after reset asserts.
- All outputs are Moore, decoded from registered state, except `rf_we`, `data_sram_we` and `retire`, which also depend on the stable class inputs.
- Latency with zero-wait memory:
  - branch (b/beq/bne): 2 cycles
  - ALU, jirl, bl: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each cycle of rdy low adds one cycle.
- `rf_we` is high exactly one cycle per writing instruction.
- `data_sram_we` is high for every cycle of a store's MEM state. The SRAM commits on the rdy cycle only.

## Structure
- Shared package `mc_pkg`:
  - state enum `mc_state_t` (3-bit, codes above)
  - `MC_RESET_PC`
  - `MC_PC_STEP`=4
- Single module. No sub-module required: PC/IR registers plus next-state logic are under 200 lines.

## Test plan
- Reset release with `inst_sram_rdy`=1 → `inst_sram_addr`=1c00_0000 in the first cycle. `state` sequence FETCH, DECODE.
- add.w with zero-wait fetch → `rf_we`=1 in cycle 4 only, `retire` in cycle 4. Next fetch address is 1c00_0004.
- ld.w with `data_sram_rdy` low for 2 MEM cycles → `data_sram_req` high 3 cycles, `data_sram_we`=0 throughout. WB in cycle 7, total 7 cycles.
- beq taken, `br_target`=1c00_0100 → retire in DECODE (cycle 2), no `rf_we`. Next `inst_sram_addr`=1c00_0100.
- st.w → `data_sram_we`=1 with req, `rf_we` never asserted, retire in MEM. A fetch at `pc`=FFFF_FFFC, not taken, wraps to 0000_0000.
- `resetn` pulsed low during a load's MEM wait → `data_sram_req` drops immediately, no `rf_we`. After release `pc`=1c00_0000 and `state`=FETCH.
